// File: rtl/aes_spi_master.sv
// Host-side serial driver for the aes accelerator: shifts {plaintext, key} out on sck/sdi,
// waits for done, then collects 128 ciphertext bits from sdo into a parallel word.
module aes_spi_master #(
  parameter int K      = 128,
  parameter int CLKDIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         valid,
  output logic [127:0] cyphertext,
  output logic         sck,
  output logic         sdi,
  output logic         load,
  input  logic         sdo,
  input  logic         done
);

  localparam int NBITS = K + 128;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SHIFT_IN  = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] SHIFT_OUT = 2'd3;

  localparam logic [15:0] HALF_END   = 16'(CLKDIV - 1);
  localparam logic [15:0] PERIOD_END = 16'(2 * CLKDIV - 1);
  localparam logic [8:0]  LAST_IN    = 9'(NBITS - 1);
  localparam logic [8:0]  LAST_OUT   = 9'd127;

  logic [1:0]       state;
  logic [15:0]      phase_cnt;
  logic [8:0]       bit_cnt;
  logic [NBITS-2:0] in_shift;
  logic [126:0]     out_shift;
  logic [1:0]       done_sync;
  logic             rise_now;
  logic             fall_now;

  // Each bit period is CLKDIV cycles low followed by CLKDIV cycles high.
  assign rise_now = (phase_cnt == HALF_END);
  assign fall_now = (phase_cnt == PERIOD_END);

  // done comes from another clock domain, so it is only trusted after two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_sync <= 2'b00;
    end else begin
      done_sync <= {done_sync[0], done};
    end
  end

  // The current sdi bit lives in the sdi flop itself, so in_shift only holds the bits still to come.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase_cnt  <= 16'd0;
      bit_cnt    <= 9'd0;
      in_shift   <= '0;
      out_shift  <= '0;
      sck        <= 1'b0;
      sdi        <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      cyphertext <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_shift  <= {plaintext[126:0], key};
            sdi       <= plaintext[127];
            load      <= 1'b1;
            busy      <= 1'b1;
            phase_cnt <= 16'd0;
            bit_cnt   <= 9'd0;
            state     <= SHIFT_IN;
          end
        end

        SHIFT_IN: begin
          if (fall_now) begin
            sck       <= 1'b0;
            phase_cnt <= 16'd0;
            if (bit_cnt == LAST_IN) begin
              load    <= 1'b0;
              sdi     <= 1'b0;
              bit_cnt <= 9'd0;
              state   <= WAIT_DONE;
            end else begin
              sdi      <= in_shift[NBITS-2];
              in_shift <= {in_shift[NBITS-3:0], 1'b0};
              bit_cnt  <= bit_cnt + 9'd1;
            end
          end else begin
            if (rise_now) begin
              sck <= 1'b1;
            end
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        WAIT_DONE: begin
          if (done_sync[1]) begin
            phase_cnt <= 16'd0;
            bit_cnt   <= 9'd0;
            state     <= SHIFT_OUT;
          end
        end

        SHIFT_OUT: begin
          // sdo is taken on the edge that ends each high phase, after the slave had a full high phase to settle.
          if (fall_now) begin
            sck       <= 1'b0;
            phase_cnt <= 16'd0;
            out_shift <= {out_shift[125:0], sdo};
            if (bit_cnt == LAST_OUT) begin
              cyphertext <= {out_shift, sdo};
              valid      <= 1'b1;
              busy       <= 1'b0;
              bit_cnt    <= 9'd0;
              state      <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end else begin
            if (rise_now) begin
              sck <= 1'b1;
            end
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
